// File: rtl/debounce_core.sv
//-----------------------------------------------------------------------------
// debounce_core
//
// Turns one raw asynchronous level (push-button, switch) into a clean,
// registered level. The raw input is brought into the clk domain through a
// two-flop synchroniser. The output only takes on a new level once the
// synchronised input has disagreed with it for N consecutive enabled clock
// edges, where N = DEBOUNCE_TIMER_ns / CLK_PERIOD_ns (at least 1).
//
// Ports
//   clk     in   system clock, rising edge
//   resetn  in   asynchronous active-low reset
//   enable  in   counting enable; while low the count is held at zero and
//                sig_o is frozen
//   sig_i   in   raw asynchronous input
//   sig_o   out  debounced level (registered, reset 0)
//   rise_o  out  one-cycle pulse in the cycle sig_o goes 0->1 (optional)
//   fall_o  out  one-cycle pulse in the cycle sig_o goes 1->0 (optional)
//
// Build option
//   DEBOUNCE_EDGE_PULSE_EN  when defined, adds rise_o/fall_o and their
//                           registers. When undefined, those ports do not
//                           exist and sig_o behaves identically.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module debounce_core #(
  parameter int CLK_PERIOD_ns     = 20,
  parameter int DEBOUNCE_TIMER_ns = 10_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic sig_i,
`ifdef DEBOUNCE_EDGE_PULSE_EN
  output logic rise_o,
  output logic fall_o,
`endif
  output logic sig_o
);

  // Required number of consecutive disagreeing samples; a timer shorter than
  // one clock period still needs one sample.
  localparam int N_RAW = DEBOUNCE_TIMER_ns / CLK_PERIOD_ns;
  localparam int N     = (N_RAW < 1) ? 1 : N_RAW;
  localparam int CW    = $clog2(N + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  // The count never goes past CNT_LAST: reaching it commits the new level and
  // clears the count in the same edge, so there is no wrap-around to guard.
  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] value);
    cnt_step = (value == CNT_LAST) ? '0 : value + CW'(1);
  endfunction

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          commit;

  // Stage p0/p1: two-flop synchroniser, runs every edge regardless of enable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sig_i;
      sync_p1 <= sync_p0;
    end
  end

  assign differ = enable && (sync_p1 != sig_o);
  assign commit = differ && (cnt == CNT_LAST);

  // Stability counter and output register. Any sample that agrees with the
  // current output (a glitch back to the old level) or a low enable restarts
  // the timing from zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      sig_o <= 1'b0;
    end else if (!differ) begin
      cnt   <= '0;
    end else begin
      cnt   <= cnt_step(cnt);
      if (commit) begin
        sig_o <= sync_p1;
      end
    end
  end

`ifdef DEBOUNCE_EDGE_PULSE_EN
  // Pulses are registered from the same commit condition as sig_o, so they
  // are high exactly in the cycle where sig_o shows its new level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      rise_o <= commit && sync_p1;
      fall_o <= commit && !sync_p1;
    end
  end
`endif

endmodule

// File: tb/tb_debounce_core.sv
`timescale 1ns/1ps

module tb_debounce_core;

  localparam int CLK_NS   = 20;
  localparam int TIMER_NS = 200;
  localparam int N        = TIMER_NS / CLK_NS;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b1;
  logic sig_i  = 1'b0;
  logic sig_o;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_o;
  logic fall_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard entries: {fall, rise, level}
  logic [2:0] exp_q[$];

  debounce_core #(
    .CLK_PERIOD_ns     (CLK_NS),
    .DEBOUNCE_TIMER_ns (TIMER_NS)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .sig_i  (sig_i),
`ifdef DEBOUNCE_EDGE_PULSE_EN
    .rise_o (rise_o),
    .fall_o (fall_o),
`endif
    .sig_o  (sig_o)
  );

  always #(CLK_NS / 2) clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // Waits (bounded) for sig_o to reach target and checks the delay from the
  // moment of the call against the allowed window.
  task automatic measure(input string name, input logic target, input int lo, input int hi);
    realtime t0;
    int      dt;
    bit      seen;
    t0   = $realtime;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      #1;
      if (sig_o === target) seen = 1'b1;
    end
    dt = int'($realtime - t0);
    n_checks++;
    if (seen && dt >= lo && dt <= hi) n_pass++;
    else $display("FAIL %s: delay %0d ns (reached=%0d), required %0d..%0d ns",
                  name, dt, seen, lo, hi);
  endtask

  // ---------------------------------------------------------------------
  // Reference model: remembers every raw sample and enable value since
  // reset. The synchroniser is modelled as a two-edge delay of the raw
  // samples. The output flips at an edge when each of the last N edges since
  // the previous flip was enabled and saw a level different from the output.
  // ---------------------------------------------------------------------
  bit raw_hist[$];
  bit en_hist[$];
  bit seen_hist[$];
  int edge_k;
  int last_change;
  bit m_out;
  bit m_rise;
  bit m_fall;
  bit win_ok;

  task automatic model_clear();
    raw_hist.delete();
    en_hist.delete();
    seen_hist.delete();
    edge_k      = 0;
    last_change = 0;
    m_out       = 1'b0;
    m_rise      = 1'b0;
    m_fall      = 1'b0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(negedge resetn);
      model_clear();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (!resetn) begin
        model_clear();
      end else begin
        edge_k++;
        raw_hist.push_back(sig_i);
        en_hist.push_back(enable);
        seen_hist.push_back((edge_k >= 3) ? raw_hist[edge_k - 3] : 1'b0);
        if (edge_k - last_change >= N) begin
          win_ok = 1'b1;
          for (int j = edge_k - N; j < edge_k; j++)
            if (!en_hist[j] || seen_hist[j] == m_out) win_ok = 1'b0;
          if (win_ok) begin
            m_rise      = !m_out;
            m_fall      = m_out;
            m_out       = !m_out;
            last_change = edge_k;
          end
        end
      end
      exp_q.push_back({m_fall, m_rise, m_out});
    end
  end

  // Monitor: compares DUT outputs with the scoreboard on the falling edge.
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sig_o", int'(sig_o), int'(e[0]));
`ifdef DEBOUNCE_EDGE_PULSE_EN
        check("rise_o", int'(rise_o), int'(e[1]));
        check("fall_o", int'(fall_o), int'(e[2]));
`endif
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus. Inputs only ever change a few ns after a rising edge (or just
  // after a falling edge for reset), never on the edge itself.
  // ---------------------------------------------------------------------
  initial begin
    // Reset, then idle at 0.
    repeat (3) @(posedge clk);
    #5 resetn = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("idle_after_reset", int'(sig_o), 0);

    // Rise latency.
    #2 sig_i = 1'b1;
    measure("rise_latency", 1'b1, 220, 241);

    // Short glitches to 0 while the output is high are rejected.
    @(posedge clk);
    #3 sig_i = 1'b0;
    #1 sig_i = 1'b1;
    #1 sig_i = 1'b0;
    #10 sig_i = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("glitch_rejected", int'(sig_o), 1);

    // Fall latency, then an immediate return to 1.
    @(posedge clk);
    #3 sig_i = 1'b0;
    measure("fall_latency", 1'b0, 220, 241);
    @(posedge clk);
    #3 sig_i = 1'b1;
    measure("rise_after_fall", 1'b1, 220, 241);

    // 8 cycles of the new level, 1 cycle back, then held: timing restarts.
    @(posedge clk);
    #3 sig_i = 1'b0;
    repeat (8) @(posedge clk);
    #3 sig_i = 1'b1;
    @(posedge clk);
    #3 sig_i = 1'b0;
    measure("restart_latency", 1'b0, 220, 241);

    // Output frozen while enable is low, follows N cycles after re-enable.
    @(posedge clk);
    #3 enable = 1'b0;
    sig_i = 1'b1;
    repeat (30) @(posedge clk);
    #1 check("frozen_while_disabled", int'(sig_o), 0);
    @(posedge clk);
    #3 enable = 1'b1;
    measure("follow_after_enable", 1'b1, 180, 201);

    // Reset in the middle of a count clears the output at once.
    @(posedge clk);
    #3 sig_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 check("async_reset_mid_count", int'(sig_o), 0);
    repeat (2) @(posedge clk);
    #5 resetn = 1'b1;

    // Randomised segments: level changes, in-cycle glitches, enable drops
    // and occasional resets, each held for a random number of cycles.
    for (int s = 0; s < 250; s++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        @(negedge clk);
        #2 resetn = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #5 resetn = 1'b1;
      end else begin
        @(posedge clk);
        #($urandom_range(1, 17));
        enable = ($urandom_range(0, 7) != 0);
        if (r < 4) begin
          sig_i = ~sig_i;
          #1 sig_i = ~sig_i;
        end else if (r < 15) begin
          sig_i = ~sig_i;
        end
      end
      repeat ($urandom_range(1, 2 * N + 4)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
